// File: rtl/scr1_dmem_responder.sv
// Memory-side responder for the core memory request bus: single-port word array
// with programmable acknowledge delay, in-order response pipe and ERR checking.
module scr1_dmem_responder #(
    parameter int unsigned MEM_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned ACK_DELAY = 0,
    parameter int unsigned RESP_LAT  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core2mem_req_i,
    input  logic        core2mem_cmd_i,
    input  logic [1:0]  core2mem_width_i,
    input  logic [31:0] core2mem_addr_i,
    input  logic [31:0] core2mem_wdata_i,
    output logic        mem2core_req_ack_o,
    output logic [31:0] mem2core_rdata_o,
    output logic [1:0]  mem2core_resp_o
);
    // Handshake: a transfer happens in any cycle with req_i=1 and req_ack_o=1;
    // all request fields are sampled in that cycle and req_ack_o is registered.
    localparam int unsigned AW = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [2:0]  cnt, cnt_next;
    logic        req_ack_q, req_ack_next;

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        req_ack_next = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ACK_DELAY == 0) begin
                    req_ack_next = 1'b1;
                end else if (core2mem_req_i) begin
                    if (ACK_DELAY == 1) begin
                        state_next   = ST_ACK;
                        req_ack_next = 1'b1;
                    end else begin
                        state_next = ST_WAIT;
                        cnt_next   = 3'(ACK_DELAY - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (!core2mem_req_i) begin
                    state_next = ST_IDLE;
                end else if (cnt == 3'd1) begin
                    // ack flag is registered, so leave one cycle early
                    state_next   = ST_ACK;
                    req_ack_next = 1'b1;
                    cnt_next     = 3'd0;
                end else begin
                    cnt_next = cnt - 3'd1;
                end
            end
            ST_ACK:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= 3'd0;
            req_ack_q <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            req_ack_q <= req_ack_next;
        end
    end

    assign mem2core_req_ack_o = req_ack_q;

    logic          hs;
    logic [31:0]   offset;
    logic          in_range;
    logic          err;
    logic [AW-1:0] idx;
    logic [3:0]    be;
    logic [31:0]   wdata_sh;

    assign hs       = core2mem_req_i & req_ack_q & ~rst;
    assign offset   = core2mem_addr_i - BASE_ADDR;
    assign in_range = {2'b00, offset[31:2]} < MEM_WORDS;
    assign idx      = offset[AW+1:2];
    assign wdata_sh = core2mem_wdata_i << {offset[1:0], 3'b000};

    always_comb begin
        err = ~in_range;
        be  = 4'b0000;
        case (core2mem_width_i)
            2'b00: be = 4'b0001 << offset[1:0];
            2'b01: begin
                be = 4'b0011 << offset[1:0];
                if (offset[0]) err = 1'b1;
            end
            2'b10: begin
                be = 4'b1111;
                if (offset[1:0] != 2'b00) err = 1'b1;
            end
            default: err = 1'b1;
        endcase
    end

    logic [31:0] mem [MEM_WORDS];

    // Array is not reset: contents survive rst.
    always_ff @(posedge clk) begin
        if (hs && core2mem_cmd_i && !err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
            end
        end
    end

    logic [RESP_LAT-1:0] pipe_vld;
    logic [RESP_LAT-1:0] pipe_err;
    logic [31:0]         pipe_rdata [RESP_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld <= '0;
            pipe_err <= '0;
            for (int i = 0; i < int'(RESP_LAT); i++) pipe_rdata[i] <= 32'd0;
        end else begin
            pipe_vld[0]   <= hs;
            pipe_err[0]   <= hs & err;
            pipe_rdata[0] <= (hs && !core2mem_cmd_i && !err) ? mem[idx] : 32'd0;
            for (int i = 1; i < int'(RESP_LAT); i++) begin
                pipe_vld[i]   <= pipe_vld[i-1];
                pipe_err[i]   <= pipe_err[i-1];
                pipe_rdata[i] <= pipe_rdata[i-1];
            end
        end
    end

    always_comb begin
        mem2core_resp_o = 2'b00;
        if (pipe_vld[RESP_LAT-1]) begin
            mem2core_resp_o = pipe_err[RESP_LAT-1] ? 2'b10 : 2'b01;
        end
    end

    assign mem2core_rdata_o = pipe_rdata[RESP_LAT-1];

endmodule

// File: tb/tb_scr1_dmem_responder.sv
// Directed bench for scr1_dmem_responder: three instances cover the
// zero-delay, delayed-ack and deep-pipeline configurations.
module tb_scr1_dmem_responder;
    localparam logic [1:0] W_B = 2'b00, W_H = 2'b01, W_W = 2'b10, W_X = 2'b11;
    localparam logic [1:0] R_IDLE = 2'b00, R_RDY = 2'b01, R_ERR = 2'b10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic        a_req, a_cmd, a_ack;
    logic [1:0]  a_width, a_resp;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic        b_req, b_cmd, b_ack;
    logic [1:0]  b_width, b_resp;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic        c_req, c_cmd, c_ack;
    logic [1:0]  c_width, c_resp;
    logic [31:0] c_addr, c_wdata, c_rdata;

    scr1_dmem_responder #(.MEM_WORDS(1024), .BASE_ADDR(32'h0), .ACK_DELAY(0), .RESP_LAT(1)) u_a (
        .clk(clk), .rst(rst), .core2mem_req_i(a_req), .core2mem_cmd_i(a_cmd),
        .core2mem_width_i(a_width), .core2mem_addr_i(a_addr), .core2mem_wdata_i(a_wdata),
        .mem2core_req_ack_o(a_ack), .mem2core_rdata_o(a_rdata), .mem2core_resp_o(a_resp));

    scr1_dmem_responder #(.MEM_WORDS(1024), .BASE_ADDR(32'h0), .ACK_DELAY(3), .RESP_LAT(2)) u_b (
        .clk(clk), .rst(rst), .core2mem_req_i(b_req), .core2mem_cmd_i(b_cmd),
        .core2mem_width_i(b_width), .core2mem_addr_i(b_addr), .core2mem_wdata_i(b_wdata),
        .mem2core_req_ack_o(b_ack), .mem2core_rdata_o(b_rdata), .mem2core_resp_o(b_resp));

    scr1_dmem_responder #(.MEM_WORDS(1024), .BASE_ADDR(32'h0), .ACK_DELAY(0), .RESP_LAT(4)) u_c (
        .clk(clk), .rst(rst), .core2mem_req_i(c_req), .core2mem_cmd_i(c_cmd),
        .core2mem_width_i(c_width), .core2mem_addr_i(c_addr), .core2mem_wdata_i(c_wdata),
        .mem2core_req_ack_o(c_ack), .mem2core_rdata_o(c_rdata), .mem2core_resp_o(c_resp));

    // One transfer on instance A: ack expected in the request cycle, response next cycle.
    task automatic a_xfer(input logic cmd, input logic [1:0] width, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] exp_resp,
                          input logic [31:0] exp_rdata, input string name);
        @(posedge clk); #1;
        a_req = 1'b1; a_cmd = cmd; a_width = width; a_addr = addr; a_wdata = wdata;
        @(negedge clk);
        n_tests++;
        if (a_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL %s ack: got %b expected 1", name, a_ack);
        end
        @(posedge clk); #1;
        a_req = 1'b0;
        @(negedge clk);
        n_tests++;
        if (a_resp !== exp_resp || a_rdata !== exp_rdata) begin
            n_fail++;
            $display("FAIL %s resp: got %b/%h expected %b/%h", name, a_resp, a_rdata, exp_resp, exp_rdata);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({a_ack, a_resp, a_rdata} !== 35'd0 || {b_ack, b_resp, b_rdata} !== 35'd0 ||
            {c_ack, c_resp, c_rdata} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_state: a=%b/%b/%h b=%b/%b/%h c=%b/%b/%h expected all zero",
                     a_ack, a_resp, a_rdata, b_ack, b_resp, b_rdata, c_ack, c_resp, c_rdata);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_word_rw();
        a_xfer(1'b1, W_W, 32'h10, 32'hDEADBEEF, R_RDY, 32'h0, "word_write");
        a_xfer(1'b0, W_W, 32'h10, 32'h0, R_RDY, 32'hDEADBEEF, "word_read");
        a_xfer(1'b1, W_W, 32'hFFC, 32'h5A5A5A5A, R_RDY, 32'h0, "last_word_write");
        a_xfer(1'b0, W_W, 32'hFFC, 32'h0, R_RDY, 32'h5A5A5A5A, "last_word_read");
    endtask

    task automatic test_lanes();
        a_xfer(1'b1, W_W, 32'h20, 32'h00000000, R_RDY, 32'h0, "lane_preload");
        a_xfer(1'b1, W_B, 32'h23, 32'h000000AB, R_RDY, 32'h0, "byte_write");
        a_xfer(1'b1, W_H, 32'h20, 32'h00001234, R_RDY, 32'h0, "half_write");
        a_xfer(1'b0, W_W, 32'h20, 32'h0, R_RDY, 32'hAB001234, "lane_read");
    endtask

    task automatic test_errors();
        a_xfer(1'b0, W_H, 32'h21, 32'h0, R_ERR, 32'h0, "half_misaligned");
        a_xfer(1'b1, W_W, 32'h22, 32'hFFFFFFFF, R_ERR, 32'h0, "word_misaligned_write");
        a_xfer(1'b0, W_W, 32'h20, 32'h0, R_RDY, 32'hAB001234, "mem_unchanged");
        a_xfer(1'b0, W_X, 32'h20, 32'h0, R_ERR, 32'h0, "illegal_width");
        a_xfer(1'b0, W_W, 32'h1000, 32'h0, R_ERR, 32'h0, "out_of_range");
    endtask

    // Write then read of the same word on consecutive cycles.
    task automatic test_back_to_back();
        @(posedge clk); #1;
        a_req = 1'b1; a_cmd = 1'b1; a_width = W_W; a_addr = 32'h30; a_wdata = 32'hCAFEF00D;
        @(negedge clk);
        n_tests++;
        if (a_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ack0: got %b expected 1", a_ack);
        end
        @(posedge clk); #1;
        a_cmd = 1'b0; a_wdata = 32'h0;
        @(negedge clk);
        n_tests++;
        if (a_ack !== 1'b1 || a_resp !== R_RDY || a_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL b2b_write_resp: got %b/%b/%h expected 1/01/00000000", a_ack, a_resp, a_rdata);
        end
        @(posedge clk); #1;
        a_req = 1'b0;
        @(negedge clk);
        n_tests++;
        if (a_resp !== R_RDY || a_rdata !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL b2b_read_resp: got %b/%h expected 01/cafef00d", a_resp, a_rdata);
        end
    endtask

    // Instance B: req at cycle 0 -> ack at cycle 3 -> resp at cycle 5.
    task automatic b_xfer(input logic cmd, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input string name);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            b_req = 1'b1; b_cmd = cmd; b_width = W_W; b_addr = addr; b_wdata = wdata;
            @(negedge clk);
            n_tests++;
            if (b_ack !== (k == 3) || b_resp !== R_IDLE) begin
                n_fail++;
                $display("FAIL %s cycle%0d: ack=%b resp=%b expected ack=%0d resp=00", name, k, b_ack, b_resp, k == 3);
            end
        end
        @(posedge clk); #1;
        b_req = 1'b0;
        @(negedge clk);
        n_tests++;
        if (b_ack !== 1'b0 || b_resp !== R_IDLE) begin
            n_fail++;
            $display("FAIL %s cycle4: ack=%b resp=%b expected 0/00", name, b_ack, b_resp);
        end
        @(negedge clk);
        n_tests++;
        if (b_resp !== R_RDY || b_rdata !== exp_rdata) begin
            n_fail++;
            $display("FAIL %s cycle5: got %b/%h expected 01/%h", name, b_resp, b_rdata, exp_rdata);
        end
        @(negedge clk);
        n_tests++;
        if (b_resp !== R_IDLE) begin
            n_fail++;
            $display("FAIL %s cycle6: resp=%b expected 00", name, b_resp);
        end
    endtask

    task automatic test_ack_delay();
        b_xfer(1'b1, 32'h8, 32'h11223344, 32'h0, "delay_write");
        b_xfer(1'b0, 32'h8, 32'h0, 32'h11223344, "delay_read");
    endtask

    task automatic test_ack_drop();
        @(posedge clk); #1;
        b_req = 1'b1; b_cmd = 1'b0; b_width = W_W; b_addr = 32'h8;
        @(posedge clk); #1;
        b_req = 1'b0;
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            n_tests++;
            if (b_ack !== 1'b0 || b_resp !== R_IDLE) begin
                n_fail++;
                $display("FAIL drop_cycle%0d: ack=%b resp=%b expected 0/00", k, b_ack, b_resp);
            end
            @(posedge clk);
        end
    endtask

    // Instance C: four back-to-back requests, responses 4 cycles later in order.
    task automatic c_burst(input logic cmd, input logic [31:0] base, input string name);
        for (int k = 0; k < 9; k++) begin
            @(posedge clk); #1;
            c_req = (k < 4); c_cmd = cmd; c_width = W_W;
            c_addr = base + 32'(4 * k); c_wdata = 32'(k + 1);
            @(negedge clk);
            n_tests++;
            if (k < 4 && (c_ack !== 1'b1 || c_resp !== R_IDLE)) begin
                n_fail++;
                $display("FAIL %s cycle%0d: ack=%b resp=%b expected 1/00", name, k, c_ack, c_resp);
            end else if (k >= 4 && k < 8 &&
                         (c_resp !== R_RDY || c_rdata !== (cmd ? 32'h0 : 32'(k - 3)))) begin
                n_fail++;
                $display("FAIL %s cycle%0d: got %b/%h expected 01/%h", name, k, c_resp, c_rdata,
                         cmd ? 32'h0 : 32'(k - 3));
            end else if (k == 8 && c_resp !== R_IDLE) begin
                n_fail++;
                $display("FAIL %s cycle8: resp=%b expected 00", name, c_resp);
            end
        end
    endtask

    task automatic test_pipeline();
        c_burst(1'b1, 32'h0, "pipe_write");
        c_burst(1'b0, 32'h0, "pipe_read");
    endtask

    task automatic test_reset_mid_op();
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            c_req = 1'b1; c_cmd = 1'b0; c_width = W_W; c_addr = 32'h4 + 32'(4 * k);
        end
        // write attempted in the first reset cycle must not land
        @(posedge clk); #1;
        rst = 1'b1; c_cmd = 1'b1; c_addr = 32'h0; c_wdata = 32'h00000BAD;
        @(posedge clk); #1;
        c_req = 1'b0;
        @(negedge clk);
        n_tests++;
        if (c_ack !== 1'b0 || c_resp !== R_IDLE || c_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_hold: got %b/%b/%h expected 0/00/00000000", c_ack, c_resp, c_rdata);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_tests++;
            if (c_resp !== R_IDLE) begin
                n_fail++;
                $display("FAIL rst_flush%0d: resp=%b expected 00", k, c_resp);
            end
            @(posedge clk); #1;
        end
        c_burst(1'b0, 32'h0, "reread_after_rst");
    endtask

    initial begin
        a_req = 1'b0; a_cmd = 1'b0; a_width = W_W; a_addr = 32'h0; a_wdata = 32'h0;
        b_req = 1'b0; b_cmd = 1'b0; b_width = W_W; b_addr = 32'h0; b_wdata = 32'h0;
        c_req = 1'b0; c_cmd = 1'b0; c_width = W_W; c_addr = 32'h0; c_wdata = 32'h0;
        test_reset();
        test_word_rw();
        test_lanes();
        test_errors();
        test_back_to_back();
        test_ack_delay();
        test_ack_drop();
        test_pipeline();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
